// File: rtl/top_video_system_if.sv
// Video bus between the raster core and the board pins.
// The core drives every signal on this bus from registers. It updates them
// on each rising pixel clock edge, and nothing on the bus waits for the
// other side. The raster keeps running, so the bus has no valid/ready
// handshake.
interface vga_if;
    logic        hs;     // horizontal sync, active-low
    logic        vs;     // vertical sync, active-low
    logic        blank;  // 1 = active pixel, 0 = blanked
    logic        sync;   // composite sync, unused and held at 0
    logic [23:0] rgb;    // {R[7:0], G[7:0], B[7:0]}

    modport master (output hs, vs, blank, sync, rgb);
    modport slave  (input  hs, vs, blank, sync, rgb);
endinterface

// File: rtl/top_video_system.sv
// Video-controller top. The raster generator feeds the registered video bus
// with a switch-selectable test pattern. The block also drives the
// heartbeat, frame-toggle and switch-echo LEDs.

module video_core #(
    parameter int HDISP     = 800,
    parameter int VDISP     = 480,
    parameter int HFP       = 40,
    parameter int HPULSE    = 48,
    parameter int HBP       = 40,
    parameter int VFP       = 13,
    parameter int VPULSE    = 3,
    parameter int VBP       = 29,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] sw_i,
    vga_if.master      vga,
    output logic [7:0] led_o
);
    localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
    localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int DW     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic          h_last, v_last, div_last;
    logic          blink_q, frame_q;
    logic [3:0]    sw_q;

    logic          hs_q, vs_q, blank_q;
    logic [23:0]   rgb_q;
    logic          hs_d, vs_d, blank_d;
    logic [23:0]   rgb_d;
    logic [2:0]    bar_idx;
    logic          grid_on;

    // Next raster position: h runs every cycle and v advances on each h wrap.
    always_comb begin
        h_last  = (32'(h_cnt_q) == HTOTAL - 1);
        v_last  = (32'(v_cnt_q) == VTOTAL - 1);
        h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Heartbeat divider: wraps after BLINK_DIV cycles, which is one LED[0] toggle.
    always_comb begin
        div_last = (32'(div_q) == BLINK_DIV - 1);
        div_d    = div_last ? '0 : div_q + 1'b1;
    end

    // Sync, blank and pattern for the current counter position. These are
    // registered below, so the pins lag the counters by one cycle.
    always_comb begin
        hs_d    = !((32'(h_cnt_q) >= HDISP + HFP) && (32'(h_cnt_q) < HDISP + HFP + HPULSE));
        vs_d    = !((32'(v_cnt_q) >= VDISP + VFP) && (32'(v_cnt_q) < VDISP + VFP + VPULSE));
        blank_d = (32'(h_cnt_q) < HDISP) && (32'(v_cnt_q) < VDISP);
        bar_idx = 3'((32'(h_cnt_q) * 32'd8) / 32'(HDISP));
        grid_on = (h_cnt_q[3:0] == 4'd0) || (v_cnt_q[3:0] == 4'd0);
        rgb_d   = 24'h000000;
        if (blank_d) begin
            if (sw_i[0]) begin
                rgb_d = {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
            end else if (grid_on) begin
                rgb_d = 24'hFFFFFF;
            end
        end
    end

    // Raster counters, divider and LED state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            div_q   <= '0;
            blink_q <= 1'b0;
            frame_q <= 1'b0;
            sw_q    <= 4'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            div_q   <= div_d;
            sw_q    <= sw_i;
            if (div_last) begin
                blink_q <= !blink_q;
            end
            // Toggle on the edge that moves the raster from the last pixel
            // of the frame back to (0,0).
            if (h_last && v_last) begin
                frame_q <= !frame_q;
            end
        end
    end

    // Output registers for the video bus.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            rgb_q   <= 24'h000000;
        end else begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            rgb_q   <= rgb_d;
        end
    end

    assign vga.hs    = hs_q;
    assign vga.vs    = vs_q;
    assign vga.blank = blank_q;
    assign vga.sync  = 1'b0;
    assign vga.rgb   = rgb_q;
    assign led_o     = {sw_q, 2'b00, frame_q, blink_q};
endmodule

module top_video_system #(
    parameter int HDISP     = 800,
    parameter int VDISP     = 480,
    parameter int HFP       = 40,
    parameter int HPULSE    = 48,
    parameter int HBP       = 40,
    parameter int VFP       = 13,
    parameter int VPULSE    = 3,
    parameter int VBP       = 29,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        FPGA_CLK1_50,
    input  logic        RST,
    input  logic [3:0]  SW,
    output logic [7:0]  LED,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK,
    output logic        VGA_SYNC,
    output logic [23:0] VGA_RGB
);
    vga_if u_vga ();

    video_core #(
        .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .BLINK_DIV(BLINK_DIV)
    ) u_core (
        .clk_i (FPGA_CLK1_50),
        .rst_i (RST),
        .sw_i  (SW),
        .vga   (u_vga),
        .led_o (LED)
    );

    assign VGA_CLK   = FPGA_CLK1_50;
    assign VGA_HS    = u_vga.hs;
    assign VGA_VS    = u_vga.vs;
    assign VGA_BLANK = u_vga.blank;
    assign VGA_SYNC  = u_vga.sync;
    assign VGA_RGB   = u_vga.rgb;
endmodule

// File: tb/tb_top_video_system.sv
// Directed bench for top_video_system at 160x90 with BLINK_DIV=10.
// The variable edges counts rising edges since reset was released. The
// pixel on the pins after a sample is pixel index edges-1.
`timescale 1ns/1ps
module tb_top_video_system;
    localparam int HT    = 288;
    localparam int VT    = 135;
    localparam int FRAME = HT * VT;  // 38880

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sw  = 4'd0;
    logic [7:0]  led;
    logic        vga_clk, vga_hs, vga_vs, vga_blank, vga_sync;
    logic [23:0] vga_rgb;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;

    // Clock
    always #10 clk = ~clk;

    top_video_system #(
        .HDISP(160), .VDISP(90), .BLINK_DIV(10)
    ) dut (
        .FPGA_CLK1_50 (clk),
        .RST          (rst),
        .SW           (sw),
        .LED          (led),
        .VGA_CLK      (vga_clk),
        .VGA_HS       (vga_hs),
        .VGA_VS       (vga_vs),
        .VGA_BLANK    (vga_blank),
        .VGA_SYNC     (vga_sync),
        .VGA_RGB      (vga_rgb)
    );

    // Screen-side view of the video pins
    vga_if scr ();
    assign scr.hs    = vga_hs;
    assign scr.vs    = vga_vs;
    assign scr.blank = vga_blank;
    assign scr.sync  = vga_sync;
    assign scr.rgb   = vga_rgb;

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    // Advance until the pins show pixel (h, v); bounded by one frame.
    task automatic advance_to(input int h, input int v);
        int target;
        target = v * HT + h;
        for (int n = 0; n <= FRAME; n++) begin
            if (((edges - 1) % FRAME) == target) return;
            tick();
        end
        checks++; failures++;
        $display("FAIL advance_to(%0d,%0d): pixel never reached", h, v);
    endtask

    task automatic test_reset();
        #60;
        checks++;
        if ({scr.hs, scr.vs, scr.blank, scr.sync} !== 4'b1100) begin
            failures++; $display("FAIL reset_ctrl got=%b want=1100", {scr.hs, scr.vs, scr.blank, scr.sync});
        end
        checks++;
        if (scr.rgb !== 24'h0) begin
            failures++; $display("FAIL reset_rgb got=%h want=000000", scr.rgb);
        end
        checks++;
        if (led !== 8'h00) begin
            failures++; $display("FAIL reset_led got=%h want=00", led);
        end
        #68;
        rst = 1'b0;
        tick();
        checks++;
        if ({scr.blank, scr.rgb} !== {1'b1, 24'hFFFFFF}) begin
            failures++; $display("FAIL first_pixel got=%b/%h want=1/ffffff", scr.blank, scr.rgb);
        end
        checks++;
        if (vga_clk !== clk) begin
            failures++; $display("FAIL vga_clk got=%b want=%b", vga_clk, clk);
        end
    endtask

    task automatic test_grid();
        sw = 4'd0;
        advance_to(16, 5);
        checks++;
        if (scr.rgb !== 24'hFFFFFF) begin
            failures++; $display("FAIL grid_16_5 got=%h want=ffffff", scr.rgb);
        end
        advance_to(5, 32);
        checks++;
        if (scr.rgb !== 24'hFFFFFF) begin
            failures++; $display("FAIL grid_5_32 got=%h want=ffffff", scr.rgb);
        end
        advance_to(5, 33);
        checks++;
        if (scr.rgb !== 24'h000000) begin
            failures++; $display("FAIL grid_5_33 got=%h want=000000", scr.rgb);
        end
    endtask

    // Separate grid-black check at (5,5) inside frame ordering would require
    // revisiting earlier lines, so it is done after the mid-frame reset.

    task automatic test_line_timing();
        int blank_cnt, hs_cnt, hs_first, blank_end;
        blank_cnt = 0; hs_cnt = 0; hs_first = -1; blank_end = -1;
        advance_to(0, 40);
        for (int i = 0; i < HT; i++) begin
            if (scr.blank === 1'b1) blank_cnt++;
            else if (blank_end < 0) blank_end = i;
            if (scr.hs === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
            end
            tick();
        end
        checks++;
        if (blank_cnt != 160 || blank_end != 160) begin
            failures++; $display("FAIL line_blank got=%0d/%0d want=160/160", blank_cnt, blank_end);
        end
        checks++;
        if (hs_cnt != 48) begin
            failures++; $display("FAIL line_hs_width got=%0d want=48", hs_cnt);
        end
        checks++;
        if (hs_first != 200) begin
            failures++; $display("FAIL line_hs_start got=%0d want=200", hs_first);
        end
    endtask

    task automatic test_bars();
        sw = 4'b0001;
        advance_to(0, 50);
        checks++;
        if (scr.rgb !== 24'h000000) begin
            failures++; $display("FAIL bar_x0 got=%h want=000000", scr.rgb);
        end
        advance_to(20, 50);
        checks++;
        if (scr.rgb !== 24'h0000FF) begin
            failures++; $display("FAIL bar_x20 got=%h want=0000ff", scr.rgb);
        end
        advance_to(100, 50);
        checks++;
        if (scr.rgb !== 24'hFF00FF) begin
            failures++; $display("FAIL bar_x100 got=%h want=ff00ff", scr.rgb);
        end
        advance_to(159, 50);
        checks++;
        if (scr.rgb !== 24'hFFFFFF) begin
            failures++; $display("FAIL bar_x159 got=%h want=ffffff", scr.rgb);
        end
        advance_to(160, 50);
        checks++;
        if ({scr.blank, scr.rgb} !== {1'b0, 24'h0}) begin
            failures++; $display("FAIL bar_hblank got=%b/%h want=0/000000", scr.blank, scr.rgb);
        end
        advance_to(100, 95);
        checks++;
        if ({scr.blank, scr.rgb} !== {1'b0, 24'h0}) begin
            failures++; $display("FAIL bar_vblank got=%b/%h want=0/000000", scr.blank, scr.rgb);
        end
    endtask

    task automatic test_leds();
        int prev_t, toggles;
        logic prev_b;
        sw = 4'b1010;
        #2;
        checks++;
        if (led[7:4] !== 4'b0001) begin
            failures++; $display("FAIL led_sw_early got=%b want=0001", led[7:4]);
        end
        tick();
        checks++;
        if ({led[7:4], led[3:2]} !== 6'b101000) begin
            failures++; $display("FAIL led_sw got=%b want=101000", {led[7:4], led[3:2]});
        end
        prev_t = -1; toggles = 0; prev_b = led[0];
        for (int i = 0; i < 45; i++) begin
            tick();
            if (led[0] !== prev_b) begin
                toggles++;
                if (prev_t >= 0) begin
                    checks++;
                    if (edges - prev_t != 10) begin
                        failures++; $display("FAIL blink_period got=%0d want=10", edges - prev_t);
                    end
                end
                prev_t = edges;
                prev_b = led[0];
            end
        end
        checks++;
        if (toggles < 4) begin
            failures++; $display("FAIL blink_count got=%0d want>=4", toggles);
        end
    endtask

    task automatic test_frame();
        int vs_low, fall1, fall2, tog, tog1;
        logic pvs, pled1;
        vs_low = 0; fall1 = -1; fall2 = -1; tog = 0; tog1 = -1;
        pvs = scr.vs; pled1 = led[1];
        while (edges - 1 < 2 * FRAME) begin
            tick();
            if (scr.vs === 1'b0) vs_low++;
            if (pvs === 1'b1 && scr.vs === 1'b0) begin
                if (fall1 < 0) fall1 = edges - 1;
                else if (fall2 < 0) fall2 = edges - 1;
            end
            if (led[1] !== pled1) begin
                tog++;
                if (tog1 < 0) tog1 = edges - 1;
            end
            pvs = scr.vs; pled1 = led[1];
        end
        checks++;
        if (vs_low != 2 * 864) begin
            failures++; $display("FAIL vs_width got=%0d want=1728", vs_low);
        end
        checks++;
        if (fall1 != 103 * HT) begin
            failures++; $display("FAIL vs_start got=%0d want=%0d", fall1, 103 * HT);
        end
        checks++;
        if (fall2 - fall1 != FRAME) begin
            failures++; $display("FAIL frame_period got=%0d want=%0d", fall2 - fall1, FRAME);
        end
        checks++;
        if (tog != 2 || tog1 != FRAME - 1) begin
            failures++; $display("FAIL led1_toggle got=%0d@%0d want=2@%0d", tog, tog1, FRAME - 1);
        end
    endtask

    task automatic test_reset_mid_frame();
        advance_to(70, 20);
        rst = 1'b1;
        #2;
        checks++;
        if (led !== 8'h00) begin
            failures++; $display("FAIL midrst_led got=%h want=00", led);
        end
        checks++;
        if ({scr.hs, scr.vs, scr.blank, scr.rgb} !== {3'b110, 24'h0}) begin
            failures++; $display("FAIL midrst_video got=%b%b%b/%h want=110/000000", scr.hs, scr.vs, scr.blank, scr.rgb);
        end
        sw = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        edges = 0;
        tick();
        checks++;
        if ({scr.blank, scr.rgb} !== {1'b1, 24'hFFFFFF}) begin
            failures++; $display("FAIL midrst_first got=%b/%h want=1/ffffff", scr.blank, scr.rgb);
        end
        advance_to(5, 1);
        checks++;
        if ({scr.blank, scr.rgb} !== {1'b1, 24'h000000}) begin
            failures++; $display("FAIL midrst_5_1 got=%b/%h want=1/000000", scr.blank, scr.rgb);
        end
        advance_to(5, 5);
        checks++;
        if (scr.rgb !== 24'h000000) begin
            failures++; $display("FAIL grid_5_5 got=%h want=000000", scr.rgb);
        end
    endtask

    initial begin
        test_reset();
        test_grid();
        test_line_timing();
        test_bars();
        test_leds();
        test_frame();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
